// File: rtl/counter_pkg.sv
// Shared constants for the hex up/down counter: seven-segment patterns
// (active-low, bit 0 = segment a .. bit 6 = segment g) and direction codes.
package counter_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/hex_seg_decoder.sv
// One nibble to one active-low seven-segment pattern, with forced blanking.
module hex_seg_decoder
  import counter_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_LUT[nibble];

endmodule

// File: rtl/param_updown_counter_hex.sv
// Modulus up/down counter with clamped load, wrap/saturate and terminal count,
// driving DIGITS hex displays. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module param_updown_counter_hex
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter bit     SATURATE = 1'b0,
  localparam int    DIGITS   = WIDTH / 4
) (
  input  logic                  clock,
  input  logic                  clearb,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam logic [WIDTH:0] TERM = (WIDTH+1)'(MODULUS - 1);

  // The extra top bit keeps MODULUS = 2**WIDTH representable; it is always zero.
  logic [WIDTH:0] count_r;
  logic [WIDTH:0] next_cnt;

  function automatic logic [WIDTH:0] clamp_load(input logic [WIDTH:0] v);
    return (v > TERM) ? TERM : v;
  endfunction

  always_comb begin
    next_cnt = count_r;
    if (load) begin
      next_cnt = clamp_load({1'b0, load_value});
    end else if (enable) begin
      if (up_down == DIR_UP)
        next_cnt = (count_r == TERM) ? (SATURATE ? TERM : '0) : count_r + 1'b1;
      else
        next_cnt = (count_r == '0) ? (SATURATE ? '0 : TERM) : count_r - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clearb) begin
    if (clearb) count_r <= '0;
    else        count_r <= next_cnt;
  end

  assign count = count_r[WIDTH-1:0];
  assign tc    = ~clearb & enable & ~load &
                 ((up_down == DIR_UP) ? (count_r == TERM) : (count_r == '0));

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic blank;
`ifdef LEADING_ZERO_BLANK_EN
    if (k == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = ~|count_r[WIDTH-1:4*k];
    end
`else
    assign blank = 1'b0;
`endif
    hex_seg_decoder u_dec (
      .nibble (count_r[4*k +: 4]),
      .blank  (blank),
      .seg    (hex_out[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_param_updown_counter_hex.sv
// Scoreboard bench: three counter configurations share one stimulus stream and
// are checked against an arithmetic reference model.
module tb_param_updown_counter_hex;

  logic       clock = 1'b0;
  logic       clearb = 1'b1;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;

  logic [7:0]  cnt_o [3];
  logic        tc_o  [3];
  logic [13:0] hex_o [3];

  always #5 clock = ~clock;

  param_updown_counter_hex #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) u_a (
    .clock(clock), .clearb(clearb), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .count(cnt_o[0]), .tc(tc_o[0]), .hex_out(hex_o[0]));
  param_updown_counter_hex #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b0)) u_b (
    .clock(clock), .clearb(clearb), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .count(cnt_o[1]), .tc(tc_o[1]), .hex_out(hex_o[1]));
  param_updown_counter_hex #(.WIDTH(8), .MODULUS(200), .SATURATE(1'b1)) u_c (
    .clock(clock), .clearb(clearb), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .count(cnt_o[2]), .tc(tc_o[2]), .hex_out(hex_o[2]));

  typedef struct {
    int          inst;
    logic [7:0]  cnt;
    logic        tc;
    logic [13:0] hex;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  int mod_m [3] = '{256, 10, 200};
  bit sat_m [3] = '{1'b0, 1'b0, 1'b1};
  int mcnt  [3] = '{0, 0, 0};

  // Lit segments per hex digit, as drawn on a display.
  string lit_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_of(input int n);
    logic [6:0] s;
    string      l;
    s = 7'h7F;
    l = lit_tbl[n];
    for (int i = 0; i < l.len(); i++) s[l.getc(i) - "a"] = 1'b0;
    return s;
  endfunction

  function automatic logic [13:0] model_hex(input int c);
    logic [13:0] h;
    for (int k = 0; k < 2; k++) begin
      int  nib;
      bit  blank;
      nib   = (c >> (4 * k)) % 16;
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (k > 0) && ((c >> (4 * k)) == 0);
`endif
      h[7*k +: 7] = blank ? 7'h7F : seg_of(nib);
    end
    return h;
  endfunction

  function automatic int model_next(input int c, input int m, input bit s, input bit rst,
                                    input bit en, input bit ud, input bit ld, input int lv);
    if (rst) return 0;
    if (ld)  return (lv > m - 1) ? m - 1 : lv;
    if (!en) return c;
    if (ud)  return (c == m - 1) ? (s ? c : 0) : c + 1;
    return (c == 0) ? (s ? 0 : m - 1) : c - 1;
  endfunction

  task automatic step(input bit rst, input bit en, input bit ud, input bit ld,
                      input logic [7:0] lv, input string tag);
    @(posedge clock);
    #1;
    clearb = rst; enable = en; up_down = ud; load = ld; load_value = lv;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      if (rst) mcnt[i] = 0;
      e.inst = i;
      e.cnt  = 8'(mcnt[i]);
      e.tc   = !rst && en && !ld && (ud ? (mcnt[i] == mod_m[i] - 1) : (mcnt[i] == 0));
      e.hex  = model_hex(mcnt[i]);
      e.tag  = tag;
      sbq.push_back(e);
      mcnt[i] = model_next(mcnt[i], mod_m[i], sat_m[i], rst, en, ud, ld, int'(lv));
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        checks++;
        if (cnt_o[e.inst] !== e.cnt || tc_o[e.inst] !== e.tc || hex_o[e.inst] !== e.hex) begin
          errors++;
          $display("FAIL %s inst%0d: got count=%h tc=%b hex=%b, want count=%h tc=%b hex=%b",
                   e.tag, e.inst, cnt_o[e.inst], tc_o[e.inst], hex_o[e.inst],
                   e.cnt, e.tc, e.hex);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not finish within the expected time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "reset");
    repeat (12) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "up_wrap");

    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h03, "load3");
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "down_sat");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "down_sat_end");

    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, "load_prio");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "load_clamp");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "tc_at_top");

    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h0B, "load_0b");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "display_0b");

    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, "load5");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i % 2) == 0, 1'b0, 8'h00, "dir_flip");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "dir_flip_end");

    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, "load_5a");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "count_5a");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "mid_reset");
    #1;
    checks++;
    if (cnt_o[0] !== 8'h00 || tc_o[0] !== 1'b0 || hex_o[0] !== model_hex(0)) begin
      errors++;
      $display("FAIL async_reset: got count=%h tc=%b hex=%b mid-cycle, want count=00 tc=0 hex=%b",
               cnt_o[0], tc_o[0], hex_o[0], model_hex(0));
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "reset_held");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "reset_release");

    for (int i = 0; i < 600; i++) begin
      bit rst, en, ud, ld;
      rst = ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 3) != 0);
      ud  = 1'($urandom);
      step(rst, en, ud, ld, 8'($urandom), "random");
    end

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
